// File: rtl/call_return_ctrl.sv
// Call/return sequencer for a return-address stack: pushes the return PC on a call,
// pops it on a return, then issues a one-cycle PC load. All outputs come straight from flops.
module call_return_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          callReq,
  input  logic          retReq,
  input  logic [AW-1:0] pcCurrent,
  input  logic [AW-1:0] callTarget,
  input  logic          flush,
  input  logic          clearFault,
  input  logic [AW-1:0] stackOut,
  output logic          writeStack,
  output logic          readStack,
  output logic [AW-1:0] stackPc,
  output logic          pcLoad,
  output logic [AW-1:0] pcNext,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [1:0]    faultCode,
  output logic [3:0]    depth
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_WAIT,
    ST_LOAD,
    ST_FAULT
  } state_t;

  localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);
  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_OVER   = 2'b01;
  localparam logic [1:0] FC_UNDER  = 2'b10;

  state_t        state_q;
  logic          write_stack_q;
  logic          read_stack_q;
  logic [AW-1:0] stack_pc_q;
  logic          pc_load_q;
  logic [AW-1:0] pc_next_q;
  logic          busy_q;
  logic          done_q;
  logic          fault_q;
  logic [1:0]    fault_code_q;
  logic [3:0]    depth_q;

  // NOTE: every register here is updated with <= so all of them see the pre-edge
  // values of each other; a blocking = would make the result depend on statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      write_stack_q <= 1'b0;
      read_stack_q  <= 1'b0;
      stack_pc_q    <= '0;
      pc_load_q     <= 1'b0;
      pc_next_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      depth_q       <= '0;
    end else if (flush) begin
      // Abort anything in flight, forget the tracked stack and any fault.
      state_q       <= ST_IDLE;
      write_stack_q <= 1'b0;
      read_stack_q  <= 1'b0;
      pc_load_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      depth_q       <= '0;
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them.
      write_stack_q <= 1'b0;
      read_stack_q  <= 1'b0;
      pc_load_q     <= 1'b0;
      done_q        <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          // A call wins over a simultaneous return; the return is simply dropped.
          if (callReq) begin
            busy_q <= 1'b1;
            if (depth_q < DEPTH_MAX) begin
              state_q       <= ST_PUSH;
              write_stack_q <= 1'b1;
              stack_pc_q    <= pcCurrent + AW'(4);
              pc_next_q     <= callTarget;
              depth_q       <= depth_q + 4'd1;
            end else begin
              state_q      <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= FC_OVER;
            end
          end else if (retReq) begin
            busy_q <= 1'b1;
            if (depth_q != 4'd0) begin
              state_q      <= ST_POP;
              read_stack_q <= 1'b1;
              depth_q      <= depth_q - 4'd1;
            end else begin
              state_q      <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= FC_UNDER;
            end
          end
        end
        ST_PUSH: begin
          state_q   <= ST_LOAD;
          pc_load_q <= 1'b1;
          done_q    <= 1'b1;
        end
        ST_POP: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Pop data is valid during this cycle; capture it as the new PC.
          state_q   <= ST_LOAD;
          pc_next_q <= stackOut;
          pc_load_q <= 1'b1;
          done_q    <= 1'b1;
        end
        ST_LOAD: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_FAULT: begin
          if (clearFault) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign writeStack = write_stack_q;
  assign readStack  = read_stack_q;
  assign stackPc    = stack_pc_q;
  assign pcLoad     = pc_load_q;
  assign pcNext     = pc_next_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign faultCode  = fault_code_q;
  assign depth      = depth_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl: calls, returns, overflow/underflow faults,
// simultaneous requests, PC wrap, flush abort and asynchronous reset mid-operation.
module tb_call_return_ctrl;

  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          callReq, retReq, flush, clearFault;
  logic [AW-1:0] pcCurrent, callTarget, stackOut;
  logic          writeStack, readStack, pcLoad, busy, done, fault;
  logic [AW-1:0] stackPc, pcNext;
  logic [1:0]    faultCode;
  logic [3:0]    depth;

  int checks = 0;
  int errors = 0;

  call_return_ctrl #(.DEPTH(8), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .callReq    (callReq),
    .retReq     (retReq),
    .pcCurrent  (pcCurrent),
    .callTarget (callTarget),
    .flush      (flush),
    .clearFault (clearFault),
    .stackOut   (stackOut),
    .writeStack (writeStack),
    .readStack  (readStack),
    .stackPc    (stackPc),
    .pcLoad     (pcLoad),
    .pcNext     (pcNext),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .faultCode  (faultCode),
    .depth      (depth)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge; strobes must never overlap.
  task automatic tick();
    @(posedge clock);
    #1;
    check("strobe_exclusive", 32'(writeStack & readStack), 32'd0);
  endtask

  task automatic status(input string tag, input logic ws, input logic rs, input logic pl,
                        input logic dn, input logic bz, input logic ft,
                        input logic [1:0] fc, input logic [3:0] dp);
    check({tag, ".writeStack"}, 32'(writeStack), 32'(ws));
    check({tag, ".readStack"},  32'(readStack),  32'(rs));
    check({tag, ".pcLoad"},     32'(pcLoad),     32'(pl));
    check({tag, ".done"},       32'(done),       32'(dn));
    check({tag, ".busy"},       32'(busy),       32'(bz));
    check({tag, ".fault"},      32'(fault),      32'(ft));
    check({tag, ".faultCode"},  32'(faultCode),  32'(fc));
    check({tag, ".depth"},      32'(depth),      32'(dp));
  endtask

  // Full call from IDLE: push cycle, load cycle, back to idle.
  task automatic do_call(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [3:0] dp_after);
    pcCurrent = pc; callTarget = tgt; callReq = 1'b1;
    tick();
    callReq = 1'b0;
    status({tag, ".push"}, 1, 0, 0, 0, 1, 0, 2'b00, dp_after);
    check({tag, ".stackPc"}, stackPc, pc + 32'd4);
    tick();
    status({tag, ".load"}, 0, 0, 1, 1, 1, 0, 2'b00, dp_after);
    check({tag, ".pcNext"}, pcNext, tgt);
    tick();
    status({tag, ".idle"}, 0, 0, 0, 0, 0, 0, 2'b00, dp_after);
  endtask

  initial begin
    reset = 1'b0; callReq = 0; retReq = 0; flush = 0; clearFault = 0;
    pcCurrent = '0; callTarget = '0; stackOut = '0;
    #12;
    status("reset", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);
    check("reset.stackPc", stackPc, 32'd0);
    check("reset.pcNext", pcNext, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Basic call: return address 0x104, jump to 0x400.
    do_call("call", 32'h100, 32'h400, 4'd1);

    // Basic return: pop strobe, wait cycle, then load popped PC.
    retReq = 1'b1;
    tick();
    retReq = 1'b0;
    status("ret.pop", 0, 1, 0, 0, 1, 0, 2'b00, 4'd0);
    stackOut = 32'h104;
    tick();
    status("ret.wait", 0, 0, 0, 0, 1, 0, 2'b00, 4'd0);
    tick();
    status("ret.load", 0, 0, 1, 1, 1, 0, 2'b00, 4'd0);
    check("ret.pcNext", pcNext, 32'h104);
    tick();
    status("ret.idle", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);

    // Underflow, stickiness against a new call, then clearFault.
    retReq = 1'b1;
    tick();
    retReq = 1'b0;
    status("under", 0, 0, 0, 0, 1, 1, 2'b10, 4'd0);
    callReq = 1'b1;
    tick();
    callReq = 1'b0;
    status("under.sticky", 0, 0, 0, 0, 1, 1, 2'b10, 4'd0);
    clearFault = 1'b1;
    tick();
    clearFault = 1'b0;
    status("under.clear", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);

    // Simultaneous call+return at depth 2: push only, return dropped.
    do_call("c1", 32'h1000, 32'h2000, 4'd1);
    do_call("c2", 32'h1100, 32'h2100, 4'd2);
    pcCurrent = 32'h1200; callTarget = 32'h2200; callReq = 1'b1; retReq = 1'b1;
    tick();
    callReq = 1'b0; retReq = 1'b0;
    status("both.push", 1, 0, 0, 0, 1, 0, 2'b00, 4'd3);
    check("both.stackPc", stackPc, 32'h1204);
    tick();
    check("both.pcNext", pcNext, 32'h2200);
    tick();
    tick();
    status("both.no_pop", 0, 0, 0, 0, 0, 0, 2'b00, 4'd3);

    // Fill to 8, then overflow on the 9th call.
    for (int i = 4; i <= 8; i++)
      do_call("fill", 32'h3000 + 32'(i * 16), 32'h5000, 4'(i));
    pcCurrent = 32'h9000; callReq = 1'b1;
    tick();
    callReq = 1'b0;
    status("over", 0, 0, 0, 0, 1, 1, 2'b01, 4'd8);
    tick();
    status("over.sticky", 0, 0, 0, 0, 1, 1, 2'b01, 4'd8);
    clearFault = 1'b1;
    tick();
    clearFault = 1'b0;
    status("over.clear", 0, 0, 0, 0, 0, 0, 2'b00, 4'd8);

    // A call raised while a return is in progress is ignored, not queued.
    retReq = 1'b1;
    tick();
    retReq = 1'b0;
    status("busy.pop", 0, 1, 0, 0, 1, 0, 2'b00, 4'd7);
    callReq = 1'b1; stackOut = 32'h3084;
    tick();
    status("busy.wait", 0, 0, 0, 0, 1, 0, 2'b00, 4'd7);
    tick();
    callReq = 1'b0;
    status("busy.load", 0, 0, 1, 1, 1, 0, 2'b00, 4'd7);
    check("busy.pcNext", pcNext, 32'h3084);
    tick();
    status("busy.idle", 0, 0, 0, 0, 0, 0, 2'b00, 4'd7);

    // Return address wraps modulo 2^AW.
    do_call("wrap", 32'hFFFF_FFFC, 32'h600, 4'd8);

    // Flush during WAIT: no pcLoad, tracked stack emptied.
    retReq = 1'b1;
    tick();
    retReq = 1'b0;
    tick();
    status("flush.wait", 0, 0, 0, 0, 1, 0, 2'b00, 4'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    status("flush.after", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);
    tick();
    status("flush.quiet", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);

    // Flush beats clearFault and also clears an active fault.
    retReq = 1'b1;
    tick();
    retReq = 1'b0;
    status("fflush.fault", 0, 0, 0, 0, 1, 1, 2'b10, 4'd0);
    flush = 1'b1; clearFault = 1'b1;
    tick();
    flush = 1'b0; clearFault = 1'b0;
    status("fflush.after", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);

    // Asynchronous reset in PUSH clears everything before any clock edge.
    pcCurrent = 32'h700; callTarget = 32'h800; callReq = 1'b1;
    tick();
    callReq = 1'b0;
    status("rst.push", 1, 0, 0, 0, 1, 0, 2'b00, 4'd1);
    #2 reset = 1'b0;
    #1;
    status("rst.async", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);
    check("rst.stackPc", stackPc, 32'd0);
    check("rst.pcNext", pcNext, 32'd0);
    tick();
    status("rst.held", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);
    reset = 1'b1;
    tick();
    status("rst.released", 0, 0, 0, 0, 0, 0, 2'b00, 4'd0);
    do_call("rst.resume", 32'h40, 32'h80, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
